// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared forwarding selects, stage count and hazard match helper.
package pipe_ctrl_pkg;

    localparam int NUM_STAGES = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // A producer only matters if it is live, writes, targets the source and is not r0.
    function automatic logic hit(input logic vld, input logic we, input logic [4:0] dest,
                                 input logic [4:0] src, input logic rd_en);
        return vld & we & (dest == src) & (dest != 5'd0) & rd_en;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stage-side hazard inputs and control outputs of the pipeline controller.
interface pipe_ctrl_if;
    logic [4:0]  id_rj;
    logic [4:0]  id_rkd;
    logic        id_use_rj;
    logic        id_use_rkd;
    logic        id_br_taken;
    logic [4:0]  ex_dest;
    logic [4:0]  mem_dest;
    logic [4:0]  wb_dest;
    logic        ex_gr_we;
    logic        mem_gr_we;
    logic        wb_gr_we;
    logic        ex_is_load;
    logic        pc_en;
    logic        if_valid;
    logic        id_valid;
    logic        ex_valid;
    logic        mem_valid;
    logic        wb_valid;
    logic [1:0]  fwd_rj_sel;
    logic [1:0]  fwd_rkd_sel;
    logic        stall;
    logic [31:0] stall_cnt;

    modport master (
        output id_rj, id_rkd, id_use_rj, id_use_rkd, id_br_taken,
               ex_dest, mem_dest, wb_dest, ex_gr_we, mem_gr_we, wb_gr_we, ex_is_load,
        input  pc_en, if_valid, id_valid, ex_valid, mem_valid, wb_valid,
               fwd_rj_sel, fwd_rkd_sel, stall, stall_cnt
    );

    modport slave (
        input  id_rj, id_rkd, id_use_rj, id_use_rkd, id_br_taken,
               ex_dest, mem_dest, wb_dest, ex_gr_we, mem_gr_we, wb_gr_we, ex_is_load,
        output pc_en, if_valid, id_valid, ex_valid, mem_valid, wb_valid,
               fwd_rj_sel, fwd_rkd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
// hazard_fwd_unit: combinational load-use detection and operand forwarding priority.
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic     id_valid,
    input  logic     ex_valid,
    input  logic     mem_valid,
    input  logic     wb_valid,
    input  logic [4:0] id_rj,
    input  logic [4:0] id_rkd,
    input  logic     id_use_rj,
    input  logic     id_use_rkd,
    input  logic [4:0] ex_dest,
    input  logic [4:0] mem_dest,
    input  logic [4:0] wb_dest,
    input  logic     ex_gr_we,
    input  logic     mem_gr_we,
    input  logic     wb_gr_we,
    input  logic     ex_is_load,
    output logic     stall,
    output fwd_sel_e fwd_rj_sel,
    output fwd_sel_e fwd_rkd_sel
);
    logic ex_rj, ex_rkd, mem_rj, mem_rkd, wb_rj, wb_rkd;

    assign ex_rj   = hit(ex_valid, ex_gr_we, ex_dest, id_rj, id_use_rj);
    assign ex_rkd  = hit(ex_valid, ex_gr_we, ex_dest, id_rkd, id_use_rkd);
    assign mem_rj  = hit(mem_valid, mem_gr_we, mem_dest, id_rj, id_use_rj);
    assign mem_rkd = hit(mem_valid, mem_gr_we, mem_dest, id_rkd, id_use_rkd);
    assign wb_rj   = hit(wb_valid, wb_gr_we, wb_dest, id_rj, id_use_rj);
    assign wb_rkd  = hit(wb_valid, wb_gr_we, wb_dest, id_rkd, id_use_rkd);

    assign stall = id_valid & ex_is_load & (ex_rj | ex_rkd);

    // A load in EX has no data yet; the stall covers it, so fall through to older stages.
    assign fwd_rj_sel  = !id_valid ? FWD_RF : (ex_rj & ~ex_is_load) ? FWD_EX :
                         mem_rj ? FWD_MEM : wb_rj ? FWD_WB : FWD_RF;
    assign fwd_rkd_sel = !id_valid ? FWD_RF : (ex_rkd & ~ex_is_load) ? FWD_EX :
                         mem_rkd ? FWD_MEM : wb_rkd ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage valid pipeline, load-use interlock, branch squash and stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input logic      clk,
    input logic      reset,
    pipe_ctrl_if.slave bus
);
    logic [NUM_STAGES-1:0] valid;
    logic        reset_state;
    logic        stall;
    logic        br;
    logic [31:0] stall_cnt;
    fwd_sel_e    rj_sel, rkd_sel;

    hazard_fwd_unit u_hfu (
        .id_valid    (valid[1]),
        .ex_valid    (valid[2]),
        .mem_valid   (valid[3]),
        .wb_valid    (valid[4]),
        .id_rj       (bus.id_rj),
        .id_rkd      (bus.id_rkd),
        .id_use_rj   (bus.id_use_rj),
        .id_use_rkd  (bus.id_use_rkd),
        .ex_dest     (bus.ex_dest),
        .mem_dest    (bus.mem_dest),
        .wb_dest     (bus.wb_dest),
        .ex_gr_we    (bus.ex_gr_we),
        .mem_gr_we   (bus.mem_gr_we),
        .wb_gr_we    (bus.wb_gr_we),
        .ex_is_load  (bus.ex_is_load),
        .stall       (stall),
        .fwd_rj_sel  (rj_sel),
        .fwd_rkd_sel (rkd_sel)
    );

    assign br = valid[1] & bus.id_br_taken & ~stall;

    // valid[0]=IF .. valid[4]=WB; a stall freezes IF/ID and injects a bubble into EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid       <= '0;
            reset_state <= 1'b1;
            stall_cnt   <= '0;
        end else begin
            reset_state <= 1'b0;
            valid[4]    <= valid[3];
            valid[3]    <= valid[2];
            valid[2]    <= stall ? 1'b0 : valid[1];
            valid[1]    <= stall ? valid[1] : br ? 1'b0 : valid[0];
            valid[0]    <= stall ? valid[0] : 1'b1;
            stall_cnt   <= stall_cnt + {31'd0, stall};
        end
    end

    assign bus.pc_en       = ~reset_state & ~stall;
    assign bus.stall       = stall;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.if_valid    = valid[0];
    assign bus.id_valid    = valid[1];
    assign bus.ex_valid    = valid[2];
    assign bus.mem_valid   = valid[3];
    assign bus.wb_valid    = valid[4];
    assign bus.fwd_rj_sel  = rj_sel;
    assign bus.fwd_rkd_sel = rkd_sel;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized run against an occupancy-level reference model.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_asrt = 0;
    int   n_fail = 0;

    pipe_ctrl_if bus ();
    pipe_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: which of IF..WB hold a live instruction, plus bookkeeping.
    logic        m_valid [5];
    logic        m_fresh;
    logic [31:0] m_cnt;

    function automatic logic [4:0] vals();
        return {bus.wb_valid, bus.mem_valid, bus.ex_valid, bus.id_valid, bus.if_valid};
    endfunction

    function automatic logic [4:0] m_vals();
        return {m_valid[4], m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
    endfunction

    function automatic logic m_stall();
        logic on_rj, on_rkd;
        on_rj  = bus.id_use_rj && bus.ex_dest == bus.id_rj;
        on_rkd = bus.id_use_rkd && bus.ex_dest == bus.id_rkd;
        return m_valid[1] && m_valid[2] && bus.ex_gr_we && bus.ex_is_load &&
               bus.ex_dest != 0 && (on_rj || on_rkd);
    endfunction

    // Youngest producer wins; a load still in EX cannot supply data.
    function automatic logic [1:0] m_sel(input logic [4:0] src, input logic rd);
        logic [4:0] dst [3];
        logic       we  [3];
        dst = '{bus.ex_dest, bus.mem_dest, bus.wb_dest};
        we  = '{bus.ex_gr_we, bus.mem_gr_we, bus.wb_gr_we};
        if (!m_valid[1] || !rd || src == 0) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (m_valid[k+2] && we[k] && dst[k] == src && !(k == 0 && bus.ex_is_load))
                return 2'(k + 1);
        return 2'd0;
    endfunction

    task automatic m_advance(input logic st, input logic br);
        if (st) begin
            m_valid[4] = m_valid[3];
            m_valid[3] = m_valid[2];
            m_valid[2] = 1'b0;
            m_cnt++;
        end else begin
            for (int k = 4; k > 0; k--) m_valid[k] = m_valid[k-1];
            m_valid[0] = 1'b1;
            if (br) m_valid[1] = 1'b0;
        end
        m_fresh = 1'b0;
    endtask

    task automatic idle();
        bus.id_rj = 0; bus.id_rkd = 0; bus.id_use_rj = 0; bus.id_use_rkd = 0;
        bus.id_br_taken = 0; bus.ex_dest = 0; bus.mem_dest = 0; bus.wb_dest = 0;
        bus.ex_gr_we = 0; bus.mem_gr_we = 0; bus.wb_gr_we = 0; bus.ex_is_load = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) m_valid[k] = 1'b0;
        m_fresh = 1'b1;
        m_cnt = 0;
    endtask

    task automatic fill();
        repeat (5) @(negedge clk);
        for (int k = 0; k < 5; k++) m_valid[k] = 1'b1;
        m_fresh = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        @(negedge clk);
        reset = 1'b1;
        #2;
        n_asrt++;
        if (vals() !== 5'b0 || bus.stall_cnt !== 0 || bus.pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: valids=%b cnt=%0d pc_en=%b, want 00000/0/0", vals(), bus.stall_cnt, bus.pc_en);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_asrt++;
        if (bus.pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_cycle: pc_en=%b want 0", bus.pc_en);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            n_asrt++;
            if (vals() !== 5'((1 << k) - 1) || bus.pc_en !== 1'b1 || bus.stall_cnt !== 0) begin
                n_fail++;
                $display("FAIL reset_fill_%0d: valids=%b pc_en=%b cnt=%0d, want %b/1/0", k, vals(), bus.pc_en, bus.stall_cnt, 5'((1 << k) - 1));
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        fill();
        bus.ex_is_load = 1; bus.ex_gr_we = 1; bus.ex_dest = 5; bus.id_rj = 5; bus.id_use_rj = 1;
        #1;
        n_asrt++;
        if (bus.stall !== 1'b1 || bus.pc_en !== 1'b0 || bus.fwd_rj_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_detect: stall=%b pc_en=%b sel=%0d, want 1/0/0", bus.stall, bus.pc_en, bus.fwd_rj_sel);
        end
        @(posedge clk);
        #1;
        n_asrt++;
        if (vals() !== 5'b11011 || bus.stall_cnt !== 1) begin
            n_fail++;
            $display("FAIL load_use_bubble: valids=%b cnt=%0d, want 11011/1", vals(), bus.stall_cnt);
        end
        bus.ex_is_load = 0; bus.ex_gr_we = 0; bus.mem_dest = 5; bus.mem_gr_we = 1;
        #1;
        n_asrt++;
        if (bus.stall !== 1'b0 || bus.fwd_rj_sel !== 2'd2 || bus.pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_resume: stall=%b sel=%0d pc_en=%b, want 0/2/1", bus.stall, bus.fwd_rj_sel, bus.pc_en);
        end
    endtask

    task automatic test_fwd();
        do_reset();
        fill();
        bus.id_rkd = 3; bus.id_use_rkd = 1;
        bus.ex_dest = 3; bus.ex_gr_we = 1; bus.mem_dest = 3; bus.mem_gr_we = 1;
        #1;
        n_asrt++;
        if (bus.fwd_rkd_sel !== 2'd1 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_ex_over_mem: sel=%0d stall=%b, want 1/0", bus.fwd_rkd_sel, bus.stall);
        end
        bus.ex_gr_we = 0;
        #1;
        n_asrt++;
        if (bus.fwd_rkd_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL fwd_mem: sel=%0d want 2", bus.fwd_rkd_sel);
        end
        bus.mem_gr_we = 0; bus.wb_dest = 3; bus.wb_gr_we = 1;
        #1;
        n_asrt++;
        if (bus.fwd_rkd_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL fwd_wb: sel=%0d want 3", bus.fwd_rkd_sel);
        end
        bus.id_use_rkd = 0;
        #1;
        n_asrt++;
        if (bus.fwd_rkd_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL fwd_unused: sel=%0d want 0", bus.fwd_rkd_sel);
        end
    endtask

    task automatic test_r0();
        do_reset();
        fill();
        bus.id_rj = 0; bus.id_use_rj = 1; bus.ex_dest = 0; bus.ex_gr_we = 1; bus.ex_is_load = 1;
        #1;
        n_asrt++;
        if (bus.fwd_rj_sel !== 2'd0 || bus.stall !== 1'b0 || bus.pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_no_fwd: sel=%0d stall=%b pc_en=%b, want 0/0/1", bus.fwd_rj_sel, bus.stall, bus.pc_en);
        end
    endtask

    task automatic test_branch();
        do_reset();
        fill();
        bus.id_br_taken = 1;
        @(posedge clk);
        #1;
        n_asrt++;
        if (bus.id_valid !== 1'b0 || bus.ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_squash: id=%b ex=%b, want 0/1", bus.id_valid, bus.ex_valid);
        end
        bus.id_br_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        bus.id_br_taken = 1; bus.ex_is_load = 1; bus.ex_gr_we = 1; bus.ex_dest = 7;
        bus.id_rkd = 7; bus.id_use_rkd = 1;
        #1;
        n_asrt++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_stall_detect: stall=%b want 1", bus.stall);
        end
        @(posedge clk);
        #1;
        n_asrt++;
        if (bus.id_valid !== 1'b1 || bus.ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_stall_wins: id=%b ex=%b, want 1/0", bus.id_valid, bus.ex_valid);
        end
        @(posedge clk);
        #1;
        n_asrt++;
        if (bus.id_valid !== 1'b0 || bus.ex_valid !== 1'b1 || bus.stall_cnt !== 1) begin
            n_fail++;
            $display("FAIL branch_after_stall: id=%b ex=%b cnt=%0d, want 0/1/1", bus.id_valid, bus.ex_valid, bus.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        fill();
        bus.ex_is_load = 1; bus.ex_gr_we = 1; bus.ex_dest = 9; bus.id_rj = 9; bus.id_use_rj = 1;
        repeat (2) @(posedge clk);
        #1;
        n_asrt++;
        if (bus.stall !== 1'b1 || bus.stall_cnt !== 1) begin
            n_fail++;
            $display("FAIL mid_stall_setup: stall=%b cnt=%0d, want 1/1", bus.stall, bus.stall_cnt);
        end
        #1;
        reset = 1'b1;
        #1;
        n_asrt++;
        if (vals() !== 5'b0 || bus.stall_cnt !== 0 || bus.pc_en !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: valids=%b cnt=%0d pc_en=%b stall=%b, want 00000/0/0/0", vals(), bus.stall_cnt, bus.pc_en, bus.stall);
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
    endtask

    task automatic test_random();
        logic st, br;
        logic [1:0] e_rj, e_rkd;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.id_rj = 5'($urandom_range(0, 3));
            bus.id_rkd = 5'($urandom_range(0, 3));
            bus.ex_dest = 5'($urandom_range(0, 3));
            bus.mem_dest = 5'($urandom_range(0, 3));
            bus.wb_dest = 5'($urandom_range(0, 3));
            bus.id_use_rj = 1'($urandom);
            bus.id_use_rkd = 1'($urandom);
            bus.ex_gr_we = 1'($urandom);
            bus.mem_gr_we = 1'($urandom);
            bus.wb_gr_we = 1'($urandom);
            bus.ex_is_load = 1'($urandom);
            bus.id_br_taken = ($urandom_range(0, 3) == 0);
            #1;
            st = m_stall();
            br = m_valid[1] && bus.id_br_taken && !st;
            e_rj = m_sel(bus.id_rj, bus.id_use_rj);
            e_rkd = m_sel(bus.id_rkd, bus.id_use_rkd);
            n_asrt++;
            if (bus.stall !== st || bus.pc_en !== (!m_fresh && !st)) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: stall=%b pc_en=%b, want %b/%b", c, bus.stall, bus.pc_en, st, !m_fresh && !st);
            end
            n_asrt++;
            if (bus.fwd_rj_sel !== e_rj || bus.fwd_rkd_sel !== e_rkd) begin
                n_fail++;
                $display("FAIL rand_fwd[%0d]: rj=%0d rkd=%0d, want %0d/%0d", c, bus.fwd_rj_sel, bus.fwd_rkd_sel, e_rj, e_rkd);
            end
            @(posedge clk);
            #1;
            m_advance(st, br);
            n_asrt++;
            if (vals() !== m_vals() || bus.stall_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: valids=%b cnt=%0d, want %b/%0d", c, vals(), bus.stall_cnt, m_vals(), m_cnt);
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_fwd();
        test_r0();
        test_branch();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 id_rj, id_rkd  input  5 each  ID-stage source register numbers.
REQ-004 id_use_rj, id_use_rkd  input  1 each  ID instruction actually reads that source.
REQ-005 id_br_taken  input  1  branch/jump resolved taken in ID; qualified internally by id_valid.
REQ-006 ex_dest, mem_dest, wb_dest  input  5 each  destination register per stage.
REQ-007 ex_gr_we, mem_gr_we, wb_gr_we  input  1 each  stage writes the register file.
REQ-008 ex_is_load  input  1  EX instruction is ld.w; its result is not ready until MEM.
REQ-009 pc_en  output  1  PC register update enable.
REQ-010 if_valid, id_valid, ex_valid, mem_valid, wb_valid  output  1 each  stage valid bits.
REQ-011 fwd_rj_sel, fwd_rkd_sel  output  2 each  operand source: 0 regfile, 1 EX, 2 MEM, 3 WB.
REQ-012 stall  output  1  load-use interlock active this cycle.
REQ-013 stall_cnt  output  32  count of stall cycles since reset.

Function
REQ-014 Hazard match per source s: stage valid & gr_we & dest==s & dest!=0 & id_use_s.
REQ-015 stall SHALL be combinational: id_valid & EX match on rj or rkd & ex_is_load.
REQ-016 pc_en SHALL equal ~reset_state & ~stall, where reset_state is the first cycle after reset release.
REQ-017 No stall: valid bits shift one stage per cycle (wb<=mem, mem<=ex, ex<=id, id<=if), if_valid<=1.
REQ-018 Stall: if_valid and id_valid hold, ex_valid<=0 (bubble), mem/wb shift normally; latency of a stall is exactly one cycle per load-use pair.
REQ-019 Taken branch (id_valid & id_br_taken & ~stall): next-cycle id_valid<=0, squashing the wrong-path fetch; ex_valid<=1 carries the branch.
REQ-020 Branch with stall asserted in same cycle: stall wins; branch is re-evaluated next cycle.
REQ-021 Forward select priority EX > MEM > WB > regfile; EX forwarding SHALL be suppressed when ex_is_load (stall covers it).
REQ-022 Register 0 SHALL never forward; select 0 whenever source number is 0.
REQ-023 fwd_*_sel SHALL be 0 when id_valid is 0.
REQ-024 stall_cnt SHALL increment by 1 each stall cycle and wrap from 0xFFFFFFFF to 0.
REQ-025 A wb_valid & wb_gr_we write to the same register read in ID SHALL select WB (3), not regfile.

Reset
REQ-026 On reset assertion, asynchronously: all valid bits 0, stall_cnt 0, pc_en 0.
REQ-027 First edge after reset release: pc_en 1, if_valid<=1; downstream valids fill one stage per cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight instructions with no partial stall/branch effects.

Structure
REQ-029 Shared package holds fwd select constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and stage count.
REQ-030 One sub-module, hazard_fwd_unit, holds purely combinational match/priority logic; pipe_ctrl holds all state.

Verification
REQ-031 Release reset -> pc_en=1 next cycle; if..wb valid rise on cycles 1..5; stall_cnt=0.
REQ-032 ex_is_load, ex_dest=5, id_rj=5 used -> stall=1 one cycle, ex_valid=0 next, stall_cnt=1, then fwd_rj_sel=2.
REQ-033 ex_dest=3 (non-load), mem_dest=3, id_rkd=3 -> fwd_rkd_sel=1; with only wb_dest=3 -> 3.
REQ-034 id_rj=0 with ex_dest=0, ex_gr_we=1 -> fwd_rj_sel=0, stall=0.
REQ-035 id_br_taken=1 -> id_valid=0 next cycle, ex_valid=1; combined with load-use stall -> stall only, branch squash next cycle.
REQ-036 Assert reset during a stall -> all valids 0 and stall_cnt 0 immediately, without waiting for a clock edge.
